// File: rtl/apb_pkg.sv
// Shared APB slave definitions: bus widths and the transfer FSM state encoding.
package apb_pkg;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/modport_mem_array.sv
// Register-file storage for the APB memory: async clear, one write port and a
// registered read port whose output holds until the next read strobe.
module modport_mem_array
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) (
  input  logic              clk,
  input  logic              prst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge prst) begin
    if (!prst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/modport_mem.sv
// APB-style slave in front of a 512x8 memory. pready is registered and rises
// WAIT_STATES cycles after the access cycle begins; psel loss aborts a transfer.
module modport_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              prst,
  input  logic              psel,
  input  logic              pen,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready
);

  localparam logic [3:0] WAIT_CNT  = 4'(WAIT_STATES);
  localparam logic       ZERO_WAIT = (WAIT_STATES == 0);

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;

  logic              busy, setup_smp, done, abort, tick;
  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] rd_addr;

  always_ff @(posedge clk or negedge prst) begin
    if (!prst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup_smp) state_d = SETUP;
      SETUP,
      ACCESS: begin
        if (abort)          state_d = IDLE;
        else if (setup_smp) state_d = SETUP;
        else if (done)      state_d = IDLE;
        else                state_d = ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new setup is accepted from IDLE, or on a completing cycle (back-to-back).
  always_comb begin
    busy      = (state_q != IDLE);
    setup_smp = psel && !pen && (!busy || pready);
    done      = busy && pready && psel && pen;
    abort     = busy && !psel;
    tick      = busy && psel && !pready && (cnt_q != 4'd0);
    wr_en     = done && write_q;
    rd_en     = (setup_smp && !pwrite && ZERO_WAIT) ||
                (tick && (cnt_q == 4'd1) && !write_q);
    rd_addr   = setup_smp ? paddr : addr_q;
  end

  always_ff @(posedge clk or negedge prst) begin
    if (!prst) begin
      cnt_q  <= 4'd0;
      pready <= 1'b0;
    end else begin
      if (setup_smp) begin
        cnt_q  <= WAIT_CNT;
        pready <= ZERO_WAIT;
      end else if (abort || done) begin
        cnt_q  <= 4'd0;
        pready <= 1'b0;
      end else if (tick) begin
        cnt_q  <= cnt_q - 4'd1;
        pready <= (cnt_q == 4'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (setup_smp) begin
      addr_q  <= paddr;
      wdata_q <= pwdata;
      write_q <= pwrite;
    end
  end

  modport_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .prst    (prst),
    .wr_en   (wr_en),
    .wr_addr (addr_q),
    .wr_data (wdata_q),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (prdata)
  );

endmodule

// File: tb/tb_modport_mem.sv
// Directed bench for modport_mem: one zero-wait and one two-wait instance
// driven by an APB master task, with hand-computed expected values.
module tb_modport_mem;

  logic       clk;
  logic       prst;
  logic       psel   [2];
  logic       pen    [2];
  logic       pwrite [2];
  logic [8:0] paddr  [2];
  logic [7:0] pwdata [2];
  logic [7:0] prdata [2];
  logic       pready [2];

  int n_chk;
  int n_fail;

  modport_mem #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .prst(prst), .psel(psel[0]), .pen(pen[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0])
  );

  modport_mem #(.WAIT_STATES(2)) u_dut2 (
    .clk(clk), .prst(prst), .psel(psel[1]), .pen(pen[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0; pen[d] = 1'b0; pwrite[d] = 1'b0;
    paddr[d] = '0;  pwdata[d] = '0;
  endtask

  // Full transfer; returns read data and access-phase wait cycles.
  task automatic xfer(input int d, input bit wr, input logic [8:0] a,
                      input logic [7:0] wd, output logic [7:0] rd, output int waits);
    int n;
    @(negedge clk);
    psel[d] = 1'b1; pen[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(negedge clk);
    pen[d] = 1'b1;
    n = 0;
    while (!pready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    rd = prdata[d];
    waits = n;
    @(negedge clk);
    bus_idle(d);
    chk("pready_one_cycle", {31'd0, pready[d]}, 32'd0);
  endtask

  task automatic wr_op(input int d, input logic [8:0] a, input logic [7:0] wd,
                       input int exp_wait, input string tag);
    logic [7:0] rd;
    int w;
    xfer(d, 1'b1, a, wd, rd, w);
    chk(tag, w, exp_wait);
  endtask

  task automatic rd_op(input int d, input logic [8:0] a, input logic [7:0] exp,
                       input int exp_wait, input string tag);
    logic [7:0] rd;
    int w;
    xfer(d, 1'b0, a, 8'h00, rd, w);
    chk(tag, {24'd0, rd}, {24'd0, exp});
    chk({tag, "_wait"}, w, exp_wait);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    prst   = 1'b0;
    bus_idle(0);
    bus_idle(1);

    repeat (2) @(negedge clk);
    chk("rst_pready0", {31'd0, pready[0]}, 32'd0);
    chk("rst_prdata0", {24'd0, prdata[0]}, 32'd0);
    chk("rst_pready2", {31'd0, pready[1]}, 32'd0);
    chk("rst_prdata2", {24'd0, prdata[1]}, 32'd0);
    prst = 1'b1;

    rd_op(0, 9'h0A3, 8'h00, 0, "rd_after_rst");

    wr_op(0, 9'h010, 8'h5A, 0, "wr_010_wait");
    rd_op(0, 9'h010, 8'h5A, 0, "rd_010");

    wr_op(0, 9'h1FF, 8'hFF, 0, "wr_1ff_wait");
    wr_op(0, 9'h000, 8'h01, 0, "wr_000_wait");
    rd_op(0, 9'h1FF, 8'hFF, 0, "rd_1ff");
    rd_op(0, 9'h000, 8'h01, 0, "rd_000");
    rd_op(0, 9'h010, 8'h5A, 0, "rd_010_noalias");

    rd_op(1, 9'h020, 8'h00, 2, "ws2_rd_020");
    wr_op(1, 9'h020, 8'h33, 2, "ws2_wr_020_wait");
    rd_op(1, 9'h020, 8'h33, 2, "ws2_rd_020_new");

    // Abort a two-wait write one cycle into the access phase.
    wr_op(1, 9'h030, 8'h11, 2, "ws2_wr_030_wait");
    @(negedge clk);
    psel[1] = 1'b1; pen[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 9'h030; pwdata[1] = 8'h77;
    @(negedge clk);
    pen[1] = 1'b1;
    @(negedge clk);
    chk("abort_pre_pready", {31'd0, pready[1]}, 32'd0);
    bus_idle(1);
    @(negedge clk);
    chk("abort_pready_low", {31'd0, pready[1]}, 32'd0);
    rd_op(1, 9'h030, 8'h11, 2, "abort_rd_030");

    wr_op(1, 9'h040, 8'h44, 2, "ws2_wr_040_wait");
    chk("prdata_hold_on_wr", {24'd0, prdata[1]}, 32'h11);

    // Zero-wait abort: psel drops right after the setup sample.
    @(negedge clk);
    psel[0] = 1'b1; pen[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'h010; pwdata[0] = 8'h77;
    @(negedge clk);
    bus_idle(0);
    @(negedge clk);
    chk("abort0_pready_low", {31'd0, pready[0]}, 32'd0);
    rd_op(0, 9'h010, 8'h5A, 0, "abort0_rd_010");

    // Async reset in the middle of a zero-wait access cycle.
    @(negedge clk);
    psel[0] = 1'b1; pen[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'h050; pwdata[0] = 8'h99;
    @(negedge clk);
    pen[0] = 1'b1;
    #1;
    chk("mid_pready_high", {31'd0, pready[0]}, 32'd1);
    prst = 1'b0;
    #1;
    chk("async_pready_fall", {31'd0, pready[0]}, 32'd0);
    chk("async_prdata_clr", {24'd0, prdata[0]}, 32'd0);
    chk("async_prdata2_clr", {24'd0, prdata[1]}, 32'd0);
    bus_idle(0);
    @(negedge clk);
    prst = 1'b1;

    rd_op(0, 9'h010, 8'h00, 0, "clr_rd_010");
    rd_op(0, 9'h1FF, 8'h00, 0, "clr_rd_1ff");
    rd_op(0, 9'h000, 8'h00, 0, "clr_rd_000");
    rd_op(0, 9'h050, 8'h00, 0, "clr_rd_050");
    rd_op(1, 9'h020, 8'h00, 2, "clr_rd_020");
    rd_op(1, 9'h030, 8'h00, 2, "clr_rd_030");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
